// File: rtl/deck_card_fetcher.sv
// Adder-side reader of the shuffled deck memory: fetches the next card code on request,
// decodes its blackjack value and presents it under a valid/ack handshake.
module deck_card_fetcher #(
  parameter int DECK_SIZE = 52,
  parameter int ADDR_W    = 6,
  parameter int CODE_W    = 6
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_DeckReady,
  input  logic              i_NewDeck,
  input  logic              i_CardReq,
  input  logic              i_CardAck,
  input  logic [CODE_W-1:0] i_MemData,
  output logic [ADDR_W-1:0] o_Address,
  output logic              o_MemClk,
  output logic              o_CardValid,
  output logic [CODE_W-1:0] o_CardCode,
  output logic [3:0]        o_CardValue,
  output logic              o_IsAce,
  output logic              o_CardErr,
  output logic              o_DeckEmpty,
  output logic              o_Busy
);

  localparam logic [ADDR_W-1:0] LP_PTR_MAX = ADDR_W'(DECK_SIZE);
  localparam logic [CODE_W-1:0] LP_CODE_MAX = CODE_W'(DECK_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE,
    S_PRESENT
  } state_t;

  state_t            r_State, w_StateNext;
  logic [ADDR_W-1:0] r_Ptr, w_PtrNext;
  logic [ADDR_W-1:0] r_Address;
  logic              r_MemClk, r_CardValid, r_IsAce, r_CardErr, r_DeckEmpty;
  logic [CODE_W-1:0] r_CardCode;
  logic [3:0]        r_CardValue;
  logic              w_Accept, w_Capture;
  logic [CODE_W-1:0] w_Rank;
  logic [3:0]        w_Value;
  logic              w_IsAce, w_Err;

  always_comb begin
    w_StateNext = r_State;
    w_Accept    = 1'b0;
    case (r_State)
      S_IDLE: begin
        if (i_CardReq && i_DeckReady && !r_DeckEmpty) begin
          w_StateNext = S_SETUP;
          w_Accept    = 1'b1;
        end
      end
      S_SETUP:   w_StateNext = i_DeckReady ? S_STROBE  : S_IDLE;
      S_STROBE:  w_StateNext = i_DeckReady ? S_CAPTURE : S_IDLE;
      S_CAPTURE: w_StateNext = i_DeckReady ? S_PRESENT : S_IDLE;
      S_PRESENT: if (i_CardAck) w_StateNext = S_IDLE;
      default:   w_StateNext = S_IDLE;
    endcase
    // A new deck overrides everything, including an in-flight fetch.
    if (i_NewDeck) begin
      w_StateNext = S_IDLE;
      w_Accept    = 1'b0;
    end
  end

  assign w_Capture = (r_State == S_CAPTURE) && i_DeckReady && !i_NewDeck;

  always_comb begin
    w_PtrNext = r_Ptr;
    if (i_NewDeck) w_PtrNext = '0;
    else if (w_Capture && (r_Ptr != LP_PTR_MAX)) w_PtrNext = r_Ptr + 1'b1;
  end

  // Rank by subtracting whole suits; a compare chain keeps dividers out of the path.
  always_comb begin
    w_Rank = i_MemData;
    if (i_MemData >= CODE_W'(39))      w_Rank = i_MemData - CODE_W'(39);
    else if (i_MemData >= CODE_W'(26)) w_Rank = i_MemData - CODE_W'(26);
    else if (i_MemData >= CODE_W'(13)) w_Rank = i_MemData - CODE_W'(13);
    w_Err   = (i_MemData >= LP_CODE_MAX);
    w_IsAce = 1'b0;
    w_Value = 4'd10;
    if (w_Err) begin
      w_Value = 4'd0;
    end else if (w_Rank == '0) begin
      w_Value = 4'd1;
      w_IsAce = 1'b1;
    end else if (w_Rank <= CODE_W'(9)) begin
      w_Value = w_Rank[3:0] + 4'd1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_State <= S_IDLE;
    else          r_State <= w_StateNext;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Ptr       <= '0;
      r_Address   <= '0;
      r_MemClk    <= 1'b0;
      r_CardValid <= 1'b0;
      r_CardCode  <= '0;
      r_CardValue <= '0;
      r_IsAce     <= 1'b0;
      r_CardErr   <= 1'b0;
      r_DeckEmpty <= 1'b0;
    end else begin
      r_Ptr       <= w_PtrNext;
      r_DeckEmpty <= (w_PtrNext == LP_PTR_MAX);
      // Strobe is a flop tracking the STROBE state, so it never glitches and drops on abort.
      r_MemClk    <= (w_StateNext == S_STROBE);
      if (i_NewDeck)     r_Address <= '0;
      else if (w_Accept) r_Address <= r_Ptr;
      if (i_NewDeck) begin
        r_CardValid <= 1'b0;
      end else if (w_Capture) begin
        r_CardValid <= 1'b1;
        r_CardCode  <= i_MemData;
        r_CardValue <= w_Value;
        r_IsAce     <= w_IsAce;
        r_CardErr   <= w_Err;
      end else if ((r_State == S_PRESENT) && i_CardAck) begin
        r_CardValid <= 1'b0;
      end
    end
  end

  assign o_Address   = r_Address;
  assign o_MemClk    = r_MemClk;
  assign o_CardValid = r_CardValid;
  assign o_CardCode  = r_CardCode;
  assign o_CardValue = r_CardValue;
  assign o_IsAce     = r_IsAce;
  assign o_CardErr   = r_CardErr;
  assign o_DeckEmpty = r_DeckEmpty;
  assign o_Busy      = (r_State != S_IDLE);

endmodule

// File: tb/tb_deck_card_fetcher.sv
// Directed bench for deck_card_fetcher: handshake timing, decode, exhaustion, abort,
// new-deck restart and asynchronous reset.
module tb_deck_card_fetcher;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n, i_DeckReady, i_NewDeck, i_CardReq, i_CardAck;
  logic [5:0] i_MemData;
  logic [5:0] o_Address;
  logic       o_MemClk, o_CardValid;
  logic [5:0] o_CardCode;
  logic [3:0] o_CardValue;
  logic       o_IsAce, o_CardErr, o_DeckEmpty, o_Busy;

  int n_checks = 0;
  int n_errors = 0;

  deck_card_fetcher #(.DECK_SIZE(52), .ADDR_W(6), .CODE_W(6)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_DeckReady(i_DeckReady), .i_NewDeck(i_NewDeck),
    .i_CardReq(i_CardReq), .i_CardAck(i_CardAck), .i_MemData(i_MemData),
    .o_Address(o_Address), .o_MemClk(o_MemClk), .o_CardValid(o_CardValid),
    .o_CardCode(o_CardCode), .o_CardValue(o_CardValue), .o_IsAce(o_IsAce),
    .o_CardErr(o_CardErr), .o_DeckEmpty(o_DeckEmpty), .o_Busy(o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({o_Address, o_MemClk, o_CardValid, o_CardCode, o_CardValue,
                o_IsAce, o_CardErr, o_DeckEmpty, o_Busy});
  endfunction

  function automatic int exp_value(input int code);
    int r;
    if (code >= 52) return 0;
    r = code % 13;
    if (r == 0) return 1;
    if (r >= 10) return 10;
    return r + 1;
  endfunction

  task automatic new_deck();
    i_NewDeck = 1'b1;
    tick();
    i_NewDeck = 1'b0;
  endtask

  // Full request/present/ack cycle; the request-sampling edge is edge 1, valid appears at edge 4.
  task automatic do_fetch(input int code, input int exp_addr);
    i_MemData = 6'(code);
    i_CardReq = 1'b1;
    tick();
    i_CardReq = 1'b0;
    check("setup_busy", 32'(o_Busy), 1);
    check("setup_memclk", 32'(o_MemClk), 0);
    tick();
    check("strobe_memclk", 32'(o_MemClk), 1);
    check("strobe_addr", 32'(o_Address), 32'(exp_addr));
    tick();
    check("capture_memclk", 32'(o_MemClk), 0);
    check("capture_valid", 32'(o_CardValid), 0);
    check("capture_addr", 32'(o_Address), 32'(exp_addr));
    tick();
    check("present_valid", 32'(o_CardValid), 1);
    check("present_code", 32'(o_CardCode), 32'(code));
    check("present_value", 32'(o_CardValue), 32'(exp_value(code)));
    check("present_ace", 32'(o_IsAce), 32'((code < 52) && (code % 13 == 0)));
    check("present_err", 32'(o_CardErr), 32'(code >= 52));
    $display("fetch addr=%0d code=%0d value=%0d ace=%0d err=%0d",
             o_Address, o_CardCode, o_CardValue, o_IsAce, o_CardErr);
    i_CardAck = 1'b1;
    tick();
    i_CardAck = 1'b0;
    check("ack_valid", 32'(o_CardValid), 0);
    check("ack_busy", 32'(o_Busy), 0);
  endtask

  initial begin
    int t2_codes[4] = '{17, 22, 25, 13};
    i_Rst_n = 1'b0; i_DeckReady = 1'b0; i_NewDeck = 1'b0;
    i_CardReq = 1'b0; i_CardAck = 1'b0; i_MemData = '0;
    #3;
    check("reset_outputs", all_outs(), 0);
    #9;
    i_Rst_n = 1'b1;
    i_DeckReady = 1'b1;
    tick();

    // T1: first card at address 0 is an Ace
    do_fetch(0, 0);

    // T2: decode of several codes, addresses stepping from 0
    new_deck();
    for (int i = 0; i < 4; i++) do_fetch(t2_codes[i], i);

    // T3: exhaust a full deck, then a request must do nothing
    new_deck();
    check("newdeck_empty", 32'(o_DeckEmpty), 0);
    for (int i = 0; i < 52; i++) begin
      do_fetch(i, i);
      check("deal_empty", 32'(o_DeckEmpty), 32'(i == 51));
    end
    i_CardReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("empty_memclk", 32'(o_MemClk), 0);
      check("empty_busy", 32'(o_Busy), 0);
    end
    i_CardReq = 1'b0;
    $display("empty request ignored busy=%0d memclk=%0d", o_Busy, o_MemClk);

    // T4: DeckReady drops during STROBE
    new_deck();
    do_fetch(5, 0);
    i_MemData = 6'd9;
    i_CardReq = 1'b1;
    tick();
    i_CardReq = 1'b0;
    tick();
    check("abort_strobe_memclk", 32'(o_MemClk), 1);
    i_DeckReady = 1'b0;
    tick();
    check("abort_busy", 32'(o_Busy), 0);
    check("abort_memclk", 32'(o_MemClk), 0);
    check("abort_valid", 32'(o_CardValid), 0);
    i_DeckReady = 1'b1;
    $display("abort during strobe busy=%0d", o_Busy);
    do_fetch(9, 1);

    // T5: NewDeck while the card at address 30 is presented
    new_deck();
    for (int i = 0; i < 30; i++) do_fetch((i * 7) % 52, i);
    i_MemData = 6'd40;
    i_CardReq = 1'b1;
    tick();
    i_CardReq = 1'b0;
    tick(); tick(); tick();
    check("t5_valid", 32'(o_CardValid), 1);
    check("t5_addr", 32'(o_Address), 30);
    i_NewDeck = 1'b1;
    tick();
    i_NewDeck = 1'b0;
    check("t5_newdeck_valid", 32'(o_CardValid), 0);
    check("t5_newdeck_empty", 32'(o_DeckEmpty), 0);
    check("t5_newdeck_busy", 32'(o_Busy), 0);
    $display("new deck while presenting valid=%0d", o_CardValid);
    do_fetch(40, 0);

    // T6: invalid code, then asynchronous reset mid-STROBE
    do_fetch(60, 1);
    i_MemData = 6'd3;
    i_CardReq = 1'b1;
    tick();
    i_CardReq = 1'b0;
    tick();
    check("t6_strobe_memclk", 32'(o_MemClk), 1);
    #2;
    i_Rst_n = 1'b0;
    #1;
    check("t6_async_reset", all_outs(), 0);
    $display("async reset mid-strobe outs=%0d", all_outs());
    #10;
    i_Rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
